ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the transmitter state encoding, common keyboard command bytes and the parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    RTS     = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  localparam logic [3:0] PARITY_SLOT = 4'd8;
  localparam logic [3:0] STOP_SLOT   = 4'd9;

  // The PS/2 frame uses odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Brings the asynchronous PS/2 clock and data lines into the clk domain.
// Also flags the clock falling edge, which is the moment the device expects the host to act.
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic kb_clk,
  input  logic data,
  output logic kb_clk_sync,
  output logic data_sync,
  output logic kb_clk_fall
);

  logic [2:0] clk_sh_r;
  logic [1:0] data_sh_r;

  // Shift registers; stage 1 is the usable synchronised level, stage 2 its one-cycle-old copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sh_r  <= 3'b000;
      data_sh_r <= 2'b00;
    end else begin
      clk_sh_r  <= {clk_sh_r[1:0], kb_clk};
      data_sh_r <= {data_sh_r[0], data};
    end
  end

  assign kb_clk_sync = clk_sh_r[1];
  assign data_sync   = data_sh_r[1];
  assign kb_clk_fall = clk_sh_r[2] & ~clk_sh_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift 8 bits + parity + stop,
// check the device ACK, wait for bus release. All outputs come straight from registers.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       data,
  output logic       kb_clk_oe,
  output logic       data_oe,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       bit_cnt_r, bit_cnt_s;
  logic [7:0]       byte_r, byte_s;
  logic             par_r, par_s;
  logic             nack_r, nack_s;
  logic             kb_clk_oe_r, kb_clk_oe_s;
  logic             data_oe_r, data_oe_s;
  logic             tx_ready_r;
  logic             done_r, done_s;
  logic             ack_err_r, ack_err_s;
  logic             timeout_err_r, timeout_err_s;
  logic             kb_clk_sync_s, data_sync_s, kb_clk_fall_s;
  logic             timeout_hit_s;

  ps2_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .kb_clk      (kb_clk),
    .data        (data),
    .kb_clk_sync (kb_clk_sync_s),
    .data_sync   (data_sync_s),
    .kb_clk_fall (kb_clk_fall_s)
  );

  // cnt_r times the inhibit window, then is reused as the transaction watchdog from RTS onward.
  assign timeout_hit_s = ((state_r == RTS) || (state_r == SHIFT) ||
                          (state_r == ACK) || (state_r == RELEASE)) && (cnt_r == TO_LAST);

  // Next-state and next-output decode; the watchdog overrides any bus event in the same cycle.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    bit_cnt_s     = bit_cnt_r;
    byte_s        = byte_r;
    par_s         = par_r;
    nack_s        = nack_r;
    kb_clk_oe_s   = 1'b0;
    data_oe_s     = data_oe_r;
    done_s        = 1'b0;
    ack_err_s     = 1'b0;
    timeout_err_s = 1'b0;
    if (timeout_hit_s) begin
      state_s       = IDLE;
      data_oe_s     = 1'b0;
      timeout_err_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          data_oe_s = 1'b0;
          if (tx_valid) begin
            byte_s      = tx_byte;
            par_s       = odd_parity(tx_byte);
            cnt_s       = CNT_ZERO;
            kb_clk_oe_s = 1'b1;
            data_oe_s   = (INH_LAST == CNT_ZERO);
            state_s     = INHIBIT;
          end else begin
            state_s = IDLE;
          end
        end
        INHIBIT: begin
          if (cnt_r == INH_LAST) begin
            cnt_s     = CNT_ZERO;
            bit_cnt_s = 4'd0;
            data_oe_s = 1'b1;
            state_s   = RTS;
          end else begin
            cnt_s       = cnt_r + CNT_ONE;
            kb_clk_oe_s = 1'b1;
            data_oe_s   = (cnt_r == INH_PRE);
          end
        end
        RTS: begin
          cnt_s     = cnt_r + CNT_ONE;
          bit_cnt_s = 4'd0;
          data_oe_s = 1'b1;
          state_s   = SHIFT;
        end
        SHIFT: begin
          cnt_s = cnt_r + CNT_ONE;
          if (kb_clk_fall_s) begin
            bit_cnt_s = bit_cnt_r + 4'd1;
            case (bit_cnt_r)
              PARITY_SLOT: data_oe_s = ~par_r;
              STOP_SLOT: begin
                data_oe_s = 1'b0;
                state_s   = ACK;
              end
              default: data_oe_s = ~byte_r[bit_cnt_r[2:0]];
            endcase
          end else begin
            data_oe_s = data_oe_r;
          end
        end
        ACK: begin
          cnt_s     = cnt_r + CNT_ONE;
          data_oe_s = 1'b0;
          if (kb_clk_fall_s) begin
            nack_s  = data_sync_s;
            state_s = RELEASE;
          end else begin
            state_s = ACK;
          end
        end
        RELEASE: begin
          cnt_s     = cnt_r + CNT_ONE;
          data_oe_s = 1'b0;
          if (kb_clk_sync_s && data_sync_s) begin
            done_s    = 1'b1;
            ack_err_s = nack_r;
            state_s   = IDLE;
          end else begin
            state_s = RELEASE;
          end
        end
        default: begin
          data_oe_s = 1'b0;
          state_s   = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset releases both lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      bit_cnt_r     <= 4'd0;
      byte_r        <= 8'h00;
      par_r         <= 1'b0;
      nack_r        <= 1'b0;
      kb_clk_oe_r   <= 1'b0;
      data_oe_r     <= 1'b0;
      tx_ready_r    <= 1'b1;
      done_r        <= 1'b0;
      ack_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      bit_cnt_r     <= bit_cnt_s;
      byte_r        <= byte_s;
      par_r         <= par_s;
      nack_r        <= nack_s;
      kb_clk_oe_r   <= kb_clk_oe_s;
      data_oe_r     <= data_oe_s;
      tx_ready_r    <= (state_s == IDLE);
      done_r        <= done_s;
      ack_err_r     <= ack_err_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign kb_clk_oe   = kb_clk_oe_r;
  assign data_oe     = data_oe_r;
  assign tx_ready    = tx_ready_r;
  assign done        = done_r;
  assign ack_err     = ack_err_r;
  assign timeout_err = timeout_err_r;

endmodule
